kw11l_wb: RTL and testbench

KW11L_WB -- requirements
Module: kw11l_wb

---
 rtl/kw11l_wb_if.sv | 21 ++
 rtl/kw11l_wb.sv | 134 +++++++++++++
 tb/tb_kw11l_wb.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/kw11l_wb_if.sv
// Wishbone slave port bundle for the KW11-L line clock CSR.
// The strobe arrives pre-decoded for the CSR address, so no address lines are carried.
interface kw11l_wb_if;
   logic        wb_cyc_i;
   logic        wb_stb_i;
   logic        wb_we_i;
   logic [1:0]  wb_sel_i;
   logic [15:0] wb_dat_i;
   logic [15:0] wb_dat_o;
   logic        wb_ack_o;

   modport master (
      output wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_dat_i,
      input  wb_dat_o, wb_ack_o
   );

   modport slave (
      input  wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_dat_i,
      output wb_dat_o, wb_ack_o
   );
endinterface

// File: rtl/kw11l_wb.sv
// KW11-L line time clock: tick divider, MON/IE status register and a
// vectored interrupt handshake (IDLE -> REQ -> ACK) toward the CPU.
module kw11l_wb #(
   parameter int          CLKREF = 50000000,
   parameter int          RATE   = 50,
   parameter logic [15:0] VECTOR = 16'o000100
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   kw11l_wb_if.slave   wb,
   input  logic        ena_i,
   output logic        irq_o,
   input  logic        istb_i,
   output logic [15:0] ivec_o,
   output logic        iack_o
);

   localparam int DIV = CLKREF / RATE;
   localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_ACK  = 2'd2
   } irq_state_t;

   logic [CW-1:0] div_cnt;
   logic          div_wrap;
   logic          tick;
   logic          csr_mon;
   logic          csr_ie;
   logic          pending;
   logic          bus_ack;
   logic          access;
   logic          wr_csr;
   logic          ie_next;
   logic          pend_clr;
   irq_state_t    state;
   logic          unused_bits;

   assign unused_bits = &{1'b0, wb.wb_dat_i[15:8], wb.wb_dat_i[5:0], wb.wb_sel_i[1]};

   // The divider keeps running while disabled; only the tick itself is gated.
   assign div_wrap = (div_cnt == CW'(DIV - 1));
   assign tick     = div_wrap & ena_i;

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         div_cnt <= '0;
      end else if (div_wrap) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + CW'(1);
      end
   end

   // One register access per strobe, taken on the edge where ack rises.
   assign access   = wb.wb_cyc_i & wb.wb_stb_i & ~bus_ack;
   assign wr_csr   = access & wb.wb_we_i & wb.wb_sel_i[0];
   assign ie_next  = wr_csr ? wb.wb_dat_i[6] : csr_ie;
   assign pend_clr = ((state == ST_REQ) & istb_i) | (wr_csr & ~wb.wb_dat_i[6]);

   assign wb.wb_ack_o = bus_ack;
   assign wb.wb_dat_o = bus_ack ? {8'o0, csr_mon, csr_ie, 6'o0} : 16'o0;

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         bus_ack <= 1'b0;
      end else begin
         bus_ack <= wb.wb_cyc_i & wb.wb_stb_i;
      end
   end

   // A tick beats a simultaneous MON clear, and judges pending with the freshly written IE.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         csr_mon <= 1'b0;
         csr_ie  <= 1'b0;
         pending <= 1'b0;
      end else begin
         csr_ie <= ie_next;
         if (tick) begin
            csr_mon <= 1'b1;
         end else if (wr_csr & ~wb.wb_dat_i[7]) begin
            csr_mon <= 1'b0;
         end
         pending <= (tick & ie_next) | (pending & ~pend_clr);
      end
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state  <= ST_IDLE;
         irq_o  <= 1'b0;
         iack_o <= 1'b0;
         ivec_o <= 16'o0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (pending) begin
                  state <= ST_REQ;
                  irq_o <= 1'b1;
               end
            end
            ST_REQ: begin
               if (istb_i) begin
                  state  <= ST_ACK;
                  irq_o  <= 1'b0;
                  iack_o <= 1'b1;
                  ivec_o <= VECTOR;
               end else if (!csr_ie) begin
                  state <= ST_IDLE;
                  irq_o <= 1'b0;
               end
            end
            ST_ACK: begin
               // Finish the vector handshake regardless of IE.
               if (!istb_i) begin
                  state  <= ST_IDLE;
                  iack_o <= 1'b0;
                  ivec_o <= 16'o0;
               end
            end
            default: begin
               state  <= ST_IDLE;
               irq_o  <= 1'b0;
               iack_o <= 1'b0;
               ivec_o <= 16'o0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_kw11l_wb.sv
// Self-checking bench for kw11l_wb: directed scenarios with literal expectations
// followed by randomized bus/interrupt traffic compared against a behavioural model.
module tb_kw11l_wb;
   localparam int          CLKREF = 1000;
   localparam int          RATE   = 10;
   localparam int          DIV    = CLKREF / RATE;
   localparam logic [15:0] VEC    = 16'o000100;

   logic        clk  = 1'b0;
   logic        rst  = 1'b1;
   logic        ena  = 1'b1;
   logic        istb = 1'b0;
   logic        irq;
   logic        iack;
   logic [15:0] ivec;
   logic [15:0] rd;

   int total = 0;
   int bad   = 0;

   int n = 0;
   bit m_ack, m_mon, m_ie, m_pend, m_irq, m_iack;

   kw11l_wb_if bus ();

   kw11l_wb #(
      .CLKREF(CLKREF),
      .RATE  (RATE),
      .VECTOR(VEC)
   ) dut (
      .wb_clk_i(clk),
      .wb_rst_i(rst),
      .wb      (bus),
      .ena_i   (ena),
      .irq_o   (irq),
      .istb_i  (istb),
      .ivec_o  (ivec),
      .iack_o  (iack)
   );

   always #5 clk = ~clk;

   task automatic check_output(input string nm, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %o expected %o at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: n counts edges since reset, a tick lands on every DIV-th edge.
   initial forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
         n = 0;
         m_ack = 0; m_mon = 0; m_ie = 0; m_pend = 0; m_irq = 0; m_iack = 0;
      end else begin : model_step
         bit tk, acc, wr, nie, clr;
         tk  = ena && (n % DIV == DIV - 1);
         n++;
         acc   = bus.wb_cyc_i && bus.wb_stb_i && !m_ack;
         m_ack = bus.wb_cyc_i && bus.wb_stb_i;
         wr    = acc && bus.wb_we_i && bus.wb_sel_i[0];
         nie   = wr ? bus.wb_dat_i[6] : m_ie;
         clr   = wr && !bus.wb_dat_i[6];
         if (m_iack) begin
            if (!istb) m_iack = 0;
         end else if (m_irq) begin
            if (istb) begin
               m_irq = 0; m_iack = 1; clr = 1;
            end else if (!m_ie) begin
               m_irq = 0;
            end
         end else if (m_pend) begin
            m_irq = 1;
         end
         if (tk && nie) m_pend = 1;
         else if (clr)  m_pend = 0;
         if (tk) m_mon = 1;
         else if (wr && !bus.wb_dat_i[7]) m_mon = 0;
         m_ie = nie;
      end
   end

   initial forever begin
      @(negedge clk);
      check_output("ack",  {15'd0, bus.wb_ack_o}, {15'd0, m_ack});
      check_output("dat",  bus.wb_dat_o, m_ack ? {8'o0, m_mon, m_ie, 6'o0} : 16'o0);
      check_output("irq",  {15'd0, irq}, {15'd0, m_irq});
      check_output("iack", {15'd0, iack}, {15'd0, m_iack});
      check_output("ivec", ivec, m_iack ? VEC : 16'o0);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_stimulus(input bit we, input logic [1:0] sel, input logic [15:0] d,
                                 output logic [15:0] q);
      bus.wb_cyc_i = 1; bus.wb_stb_i = 1; bus.wb_we_i = we;
      bus.wb_sel_i = sel; bus.wb_dat_i = d;
      step();
      q = bus.wb_dat_o;
      bus.wb_cyc_i = 0; bus.wb_stb_i = 0; bus.wb_we_i = 0;
      step();
   endtask

   task automatic reset_dut();
      rst = 1;
      step();
      rst = 0;
   endtask

   task automatic wait_until_n(input int target);
      while (n < target) step();
   endtask

   task automatic wait_irq(input int limit);
      for (int i = 0; i < limit && !irq; i++) step();
      check_output("irq_wait", {15'd0, irq}, 16'd1);
   endtask

   initial begin
      int hold;
      bus.wb_cyc_i = 0; bus.wb_stb_i = 0; bus.wb_we_i = 0;
      bus.wb_sel_i = 2'b00; bus.wb_dat_i = 16'o0;
      step();
      reset_dut();

      // Divider period, MON set by the first tick and cleared by a write.
      apply_stimulus(0, 2'b11, 16'o0, rd);
      check_output("rd_reset", rd, 16'o0);
      wait_until_n(98);
      apply_stimulus(0, 2'b11, 16'o0, rd);
      check_output("rd_pre_tick", rd, 16'o0);
      apply_stimulus(0, 2'b11, 16'o0, rd);
      check_output("rd_post_tick", rd, 16'o000200);
      apply_stimulus(1, 2'b11, 16'o0, rd);
      apply_stimulus(0, 2'b11, 16'o0, rd);
      check_output("rd_after_clr", rd, 16'o0);

      // Full vectored interrupt handshake.
      apply_stimulus(1, 2'b01, 16'o000100, rd);
      wait_irq(250);
      istb = 1;
      step();
      check_output("iack_hi", {15'd0, iack}, 16'd1);
      check_output("ivec_val", ivec, 16'o000100);
      check_output("irq_in_ack", {15'd0, irq}, 16'd0);
      istb = 0;
      step();
      check_output("iack_lo", {15'd0, iack}, 16'd0);
      check_output("ivec_lo", ivec, 16'o0);

      // Low byte lane not selected: write ignored.
      reset_dut();
      apply_stimulus(1, 2'b10, 16'o000100, rd);
      apply_stimulus(0, 2'b11, 16'o0, rd);
      check_output("rd_sel_hi", rd, 16'o0);
      wait_until_n(110);
      check_output("no_irq_sel_hi", {15'd0, irq}, 16'd0);
      apply_stimulus(0, 2'b11, 16'o0, rd);
      check_output("rd_mon_only", rd, 16'o000200);

      // Clearing IE while requesting withdraws the request.
      apply_stimulus(1, 2'b01, 16'o000100, rd);
      wait_irq(250);
      apply_stimulus(1, 2'b01, 16'o0, rd);
      check_output("irq_withdrawn", {15'd0, irq}, 16'd0);
      istb = 1;
      step();
      step();
      check_output("no_iack_idle", {15'd0, iack}, 16'd0);
      istb = 0;
      step();

      // Write landing on the tick edge: MON wins and the new IE raises a request.
      reset_dut();
      wait_until_n(99);
      apply_stimulus(1, 2'b01, 16'o000100, rd);
      apply_stimulus(0, 2'b11, 16'o0, rd);
      check_output("rd_tick_wr", rd, 16'o000300);
      wait_irq(5);

      // Ticks suppressed while disabled.
      reset_dut();
      ena = 0;
      for (int i = 0; i < 300; i++) step();
      apply_stimulus(0, 2'b11, 16'o0, rd);
      check_output("rd_ena_off", rd, 16'o0);
      ena = 1;

      // Reset during the vector handshake.
      reset_dut();
      apply_stimulus(1, 2'b01, 16'o000100, rd);
      wait_irq(250);
      istb = 1;
      step();
      check_output("iack_before_rst", {15'd0, iack}, 16'd1);
      #2 rst = 1;
      #1;
      check_output("iack_async_rst", {15'd0, iack}, 16'd0);
      check_output("ivec_async_rst", ivec, 16'o0);
      check_output("irq_async_rst", {15'd0, irq}, 16'd0);
      step();
      rst = 0;
      istb = 0;
      apply_stimulus(0, 2'b11, 16'o0, rd);
      check_output("rd_after_rst", rd, 16'o0);

      // Randomized traffic against the model.
      hold = 0;
      for (int c = 0; c < 20000; c++) begin
         if (hold > 0) begin
            hold--;
            if (hold == 0) begin
               bus.wb_cyc_i = 0; bus.wb_stb_i = 0;
            end
         end else if ($urandom_range(0, 7) == 0) begin
            bus.wb_cyc_i = 1; bus.wb_stb_i = 1;
            bus.wb_we_i  = 1'($urandom);
            bus.wb_sel_i = 2'($urandom);
            bus.wb_dat_i = 16'($urandom);
            hold = $urandom_range(1, 3);
         end
         if (istb) istb = ($urandom_range(0, 1) == 1);
         else      istb = irq ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 39) == 0);
         if ($urandom_range(0, 499) == 0) ena = ~ena;
         rst = ($urandom_range(0, 4999) == 0);
         step();
      end
      rst = 0;
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
